// File: rtl/vga_timing_gen_if.sv
// Display-side bundle of vga_timing_gen: look-ahead pixel coordinates,
// line/frame strobes and the delayed hs/vs/blank_n outputs.
// With VGA_TIMING_FRAME_CNT_EN defined the bundle also carries
// frame_count and odd_frame.
interface vga_timing_gen_if #(
    parameter int CNT_W  = 11,
    parameter int ADDR_W = 32
);
    logic [CNT_W-1:0]  next_x;
    logic [CNT_W-1:0]  next_y;
    logic [ADDR_W-1:0] next_addr;
    logic              next_valid;
    logic              line_start;
    logic              frame_start;
    logic              blank_n;
    logic              hs;
    logic              vs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]       frame_count;
    logic              odd_frame;

    modport master (
        output next_x, next_y, next_addr, next_valid, line_start,
               frame_start, blank_n, hs, vs, frame_count, odd_frame
    );
    modport slave (
        input  next_x, next_y, next_addr, next_valid, line_start,
               frame_start, blank_n, hs, vs, frame_count, odd_frame
    );
`else
    modport master (
        output next_x, next_y, next_addr, next_valid, line_start,
               frame_start, blank_n, hs, vs
    );
    modport slave (
        input  next_x, next_y, next_addr, next_valid, line_start,
               frame_start, blank_n, hs, vs
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// A lead stage (_p0) produces pixel coordinates, a linear framebuffer
// address and line/frame strobes; hs, vs and blank_n follow the lead stage
// through a LOOKAHEAD-deep shift register so pixel fetch can line up.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds frame_count/odd_frame.
module vga_timing_gen #(
    parameter int H_SYNC    = 88,
    parameter int H_BACK    = 47,
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 31,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 13,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int LOOKAHEAD = 2,
    parameter int CNT_W     = 11,
    parameter int ADDR_W    = 32
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               enable,
    vga_timing_gen_if.master   vif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_BEG  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_VIS_BEG  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;

    logic [CNT_W-1:0]  next_x_p0;
    logic [CNT_W-1:0]  next_y_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              vld_p0;
    logic              line_start_p0;
    logic              frame_start_p0;
    logic              hs_act_p0;
    logic              vs_act_p0;

    logic [LOOKAHEAD-1:0] hs_pn;
    logic [LOOKAHEAD-1:0] vs_pn;
    logic [LOOKAHEAD-1:0] vld_pn;

    logic h_vis;
    logic v_vis;
    logic at_origin;

    assign h_vis     = (h_cnt >= H_VIS_BEG) && (h_cnt < H_VIS_END);
    assign v_vis     = (v_cnt >= V_VIS_BEG) && (v_cnt < V_VIS_END);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // Lead stage: advance counters and register the decode of the current position
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            next_x_p0      <= '0;
            next_y_p0      <= '0;
            addr_p0        <= '0;
            vld_p0         <= 1'b0;
            line_start_p0  <= 1'b0;
            frame_start_p0 <= 1'b0;
            hs_act_p0      <= 1'b0;
            vs_act_p0      <= 1'b0;
        end else if (!enable) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            next_x_p0      <= '0;
            next_y_p0      <= '0;
            addr_p0        <= '0;
            vld_p0         <= 1'b0;
            line_start_p0  <= 1'b0;
            frame_start_p0 <= 1'b0;
            hs_act_p0      <= 1'b0;
            vs_act_p0      <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
            next_x_p0      <= h_vis ? h_cnt - H_VIS_BEG : '0;
            next_y_p0      <= v_vis ? v_cnt - V_VIS_BEG : '0;
            vld_p0         <= h_vis && v_vis;
            line_start_p0  <= (h_cnt == '0);
            frame_start_p0 <= at_origin;
            hs_act_p0      <= (h_cnt < H_SYNC_END);
            vs_act_p0      <= (v_cnt < V_SYNC_END);
            // The address advances after every visible lead cycle, so it
            // always equals next_y*H_VISIBLE + next_x while visible.
            if (at_origin) begin
                addr_p0 <= '0;
            end else if (vld_p0) begin
                addr_p0 <= addr_p0 + ADDR_W'(1);
            end
        end
    end

    // Output stages p1..pLOOKAHEAD: delay sync/blank behind the lead stage
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset || !enable) begin
            hs_pn  <= {LOOKAHEAD{~HS_POL}};
            vs_pn  <= {LOOKAHEAD{~VS_POL}};
            vld_pn <= '0;
        end else begin
            hs_pn[0]  <= hs_act_p0 ? HS_POL : ~HS_POL;
            vs_pn[0]  <= vs_act_p0 ? VS_POL : ~VS_POL;
            vld_pn[0] <= vld_p0;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                hs_pn[i]  <= hs_pn[i-1];
                vs_pn[i]  <= vs_pn[i-1];
                vld_pn[i] <= vld_pn[i-1];
            end
        end
    end

    assign vif.next_x      = next_x_p0;
    assign vif.next_y      = next_y_p0;
    assign vif.next_addr   = addr_p0;
    assign vif.next_valid  = vld_p0;
    assign vif.line_start  = line_start_p0;
    assign vif.frame_start = frame_start_p0;
    assign vif.hs          = hs_pn[LOOKAHEAD-1];
    assign vif.vs          = vs_pn[LOOKAHEAD-1];
    assign vif.blank_n     = vld_pn[LOOKAHEAD-1];

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count_p0;
    logic        first_seen;

    // Frame counter: count every frame_start except the first after reset or enable rise
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_count_p0 <= '0;
            first_seen     <= 1'b0;
        end else if (!enable) begin
            first_seen     <= 1'b0;
        end else if (at_origin) begin
            if (first_seen) begin
                frame_count_p0 <= frame_count_p0 + 16'd1;
            end
            first_seen <= 1'b1;
        end
    end

    assign vif.frame_count = frame_count_p0;
    assign vif.odd_frame   = frame_count_p0[0];
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-mode VGA sync generator.
- Generates HS/VS/blank for any timing set, with configurable sync polarity.
- Provides a look-ahead pixel coordinate and linear framebuffer address stage that leads the sync/blank outputs by LOOKAHEAD cycles, so pixel fetch pipelines can line up with the display.
- Sits between the framebuffer reader and the DAC/output pins; adds line/frame strobes and a soft enable.

Parameters:
- H_SYNC, 88, hsync width in pixels
- H_BACK, 47, horizontal back porch in pixels
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch in pixels
- V_SYNC, 3, vsync width in lines
- V_BACK, 31, vertical back porch in lines
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 13, vertical front porch in lines
- HS_POL, 1, active level of hs (1 = active-high)
- VS_POL, 1, active level of vs
- LOOKAHEAD, 2, cycles by which next_* lead hs/vs/blank_n; legal range 1..8
- CNT_W, 11, width of the h/v counters and of next_x/next_y
- ADDR_W, 32, width of next_addr; must hold H_VISIBLE*V_VISIBLE-1

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  soft run; when low, timing is held at the frame origin
- next_x  out  CNT_W  look-ahead visible column (0 when not visible)
- next_y  out  CNT_W  look-ahead visible row (0 when not visible)
- next_addr  out  ADDR_W  look-ahead linear pixel address
- next_valid  out  1  look-ahead pixel is visible
- line_start  out  1  1-cycle pulse, lead stage, h_cnt==0
- frame_start  out  1  1-cycle pulse, lead stage, h_cnt==0 && v_cnt==0
- blank_n  out  1  visible-pixel flag, delayed LOOKAHEAD cycles
- hs  out  1  horizontal sync, delayed LOOKAHEAD cycles
- vs  out  1  vertical sync, delayed LOOKAHEAD cycles

Behaviour:
- Reset is asynchronous, active-high, on vga_clk.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT; V_TOTAL is the vertical equivalent. Region order within a line/frame is sync, back porch, visible, front porch.
- Lead counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1):
  - h_cnt increments every cycle while enable=1.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 at V_TOTAL-1 on that same edge.
- Visibility in the lead stage:
  - h visible: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_VISIBLE.
  - v visible: same rule on v_cnt with the V parameters.
  - next_valid = h visible AND v visible.
  - next_x = h_cnt-(H_SYNC+H_BACK) when h visible, else 0; next_y follows the same rule on v_cnt.
- Sync in the lead stage: hs_lead is active when h_cnt < H_SYNC; vs_lead is active when v_cnt < V_SYNC (whole lines).
- All next_*, line_start and frame_start are registered and reflect the current counter state.
- next_addr:
  - 0 at frame_start.
  - Increments by 1 after each cycle in which next_valid=1; otherwise holds.
  - Hence next_addr = next_y*H_VISIBLE + next_x whenever next_valid=1; no wrap within a frame.
- Output pipeline: hs, vs and blank_n equal hs_lead (at HS_POL), vs_lead (at VS_POL) and next_valid, delayed by exactly LOOKAHEAD cycles through a shift register.
- Reset values:
  - Counters, next_x, next_y, next_addr, next_valid, line_start, frame_start: 0.
  - blank_n: 0.
  - hs = ~HS_POL, vs = ~VS_POL; every pipeline stage is loaded with these inactive values.
- enable=0: synchronously forces the counters to 0, next_* to 0, the strobes to 0, and the pipeline to inactive values.
  - On the first enabled cycle, the lead stage is at h=0, v=0 and frame_start pulses.
- enable dropped mid-frame: outputs are inactive on the next edge; no partial-frame completion.
- Simultaneous line and frame wrap: line_start and frame_start pulse in the same cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output frame_count, 16 bits, reset 0.
  - Increments on every frame_start except the first after reset or enable rise; wraps 0xFFFF to 0.
  - Adds output odd_frame = frame_count[0].
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Small timing (H 2/2/4/2 = 10, V 1/1/3/1 = 6, LOOKAHEAD=2), reset then enable=1 -> frame_start at cycle 0; next_valid first at h=4,v=2 with next_x=0, next_y=0, next_addr=0; blank_n rises 2 cycles later.
- Same configuration, run one full frame -> next_addr reaches 11 at h=7,v=4; exactly 12 next_valid cycles; frame_start period is 60 cycles.
- Same configuration, HS_POL=0, VS_POL=1 -> hs low for 2 of every 10 cycles; vs high for 10 cycles per 60; both lag the lead stage by exactly 2 cycles.
- enable deasserted at h=5,v=3 -> next edge: hs/vs/blank_n inactive, next_addr=0; on re-enable, frame_start pulses on the first cycle.
- reset asserted mid-visible -> all outputs take reset values without a clock edge.
- VGA_TIMING_FRAME_CNT_EN defined, 3 frames run -> frame_count = 0, 1, 2; odd_frame toggles each frame.
